// File: rtl/mem_bus_sequencer_pkg.sv
// Shared types and constants for the memory bus sequencer.
package mem_bus_sequencer_pkg;

   typedef enum logic [2:0] {
      S_DATA  = 3'd0,
      S_DWAIT = 3'd1,
      S_FETCH = 3'd2,
      S_FWAIT = 3'd3,
      S_STEP  = 3'd4
   } BusState_t;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // The port only ever sees whole-word addresses; byte lanes go via strobes.
   function automatic logic [31:0] wordAlign(input logic [31:0] byteAddr);
      return {byteAddr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_bus_sequencer_timeout.sv
// Wait-cycle counter for one bus transaction. terminalCount fires in the
// wait cycle that would be the TIMEOUT_CYCLES-th without a ready; a ready
// in that cycle masks it because enable is low then.
module bus_timeout_counter
   import mem_bus_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminalCount
);

   // One spare count so the counter can step past the last wait without wrapping.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] waitCount;

   // Count unanswered valid cycles; restart whenever a new wait begins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         waitCount <= '0;
      end else if (clear) begin
         waitCount <= '0;
      end else if (enable) begin
         waitCount <= waitCount + 1'b1;
      end
   end

   // Zero disables the abort entirely.
   always_comb begin
      terminalCount = enable && (TIMEOUT_CYCLES != 0) && (waitCount == LAST_WAIT);
   end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Serialises the M-stage data access and the next instruction fetch onto a
// single valid/ready memory port and holds the pipeline until both are done.
//
//   state   | meaning
//   S_DATA  | sample M-stage request, launch data access or skip to fetch
//   S_DWAIT | data access outstanding
//   S_FETCH | launch instruction fetch at PCF
//   S_FWAIT | fetch outstanding
//   S_STEP  | halt released for this single cycle
module mem_bus_sequencer
   import mem_bus_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_INSTR    = NOP_INSTR,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   output logic [31:0] Instr,
   input  logic [31:0] AluResultM,
   input  logic [31:0] WriteDataM,
   input  logic [3:0]  WmaskRawM,
   input  logic        ReadMemM,
   output logic [31:0] ReadDataM,
   output logic        halt,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        bus_error
);

   BusState_t state;
   logic      loadPending;
   logic      inWait;
   logic      timeoutHit;

   // Wait states are the only ones where the counter runs.
   always_comb begin
      inWait = (state == S_DWAIT) || (state == S_FWAIT);
   end

   bus_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uTimeout (
      .clk          (clk),
      .reset        (reset),
      .clear        (!inWait),
      .enable       (inWait && !mem_ready),
      .terminalCount(timeoutHit)
   );

   // Halt is a pure state decode so nothing from the gated datapath feeds back.
   always_comb begin
      halt = (state != S_STEP);
   end

   // Sequencer FSM and all registered port outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_DATA;
         mem_valid   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
         Instr       <= RESET_INSTR;
         ReadDataM   <= '0;
         bus_error   <= 1'b0;
         loadPending <= 1'b0;
      end else begin
         case (state)
            S_DATA: begin
               // A load flagged together with a store rides on the store
               // and still captures the returned data.
               if (ReadMemM || (|WmaskRawM)) begin
                  mem_addr    <= wordAlign(AluResultM);
                  mem_wdata   <= WriteDataM;
                  mem_wstrb   <= WmaskRawM;
                  loadPending <= ReadMemM;
                  mem_valid   <= 1'b1;
                  state       <= S_DWAIT;
               end else begin
                  loadPending <= 1'b0;
                  state       <= S_FETCH;
               end
            end
            S_DWAIT: begin
               if (mem_ready) begin
                  if (loadPending) begin
                     ReadDataM <= mem_rdata;
                  end
                  mem_valid <= 1'b0;
                  state     <= S_FETCH;
               end else if (timeoutHit) begin
                  if (loadPending) begin
                     ReadDataM <= '0;
                  end
                  bus_error <= 1'b1;
                  mem_valid <= 1'b0;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: begin
               mem_addr  <= wordAlign(PCF);
               mem_wdata <= '0;
               mem_wstrb <= '0;
               mem_valid <= 1'b1;
               state     <= S_FWAIT;
            end
            S_FWAIT: begin
               if (mem_ready) begin
                  Instr     <= mem_rdata;
                  mem_valid <= 1'b0;
                  state     <= S_STEP;
               end else if (timeoutHit) begin
                  Instr     <= RESET_INSTR;
                  bus_error <= 1'b1;
                  mem_valid <= 1'b0;
                  state     <= S_STEP;
               end
            end
            S_STEP: begin
               state <= S_DATA;
            end
            default: begin
               mem_valid <= 1'b0;
               state     <= S_DATA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Bench for mem_bus_sequencer: directed steps, then randomized steps checked
// against a per-step model of transactions, latency and returned values.
module tb_mem_bus_sequencer;

   localparam int          TMO   = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int          NEVER = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] PCF = '0;
   logic [31:0] Instr;
   logic [31:0] AluResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic [3:0]  WmaskRawM = '0;
   logic        ReadMemM = 1'b0;
   logic [31:0] ReadDataM;
   logic        halt;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = '0;
   logic        bus_error;

   int total = 0;
   int bad = 0;

   // Model of the datapath-visible state across steps.
   logic [31:0] expInstr = NOP;
   logic [31:0] expRd = '0;
   logic        expErr = 1'b0;

   // 0: ready low when idle, 1: ready high when idle, 2: random when idle
   int idleMode = 0;

   mem_bus_sequencer #(
      .RESET_INSTR   (NOP),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .PCF       (PCF),
      .Instr     (Instr),
      .AluResultM(AluResultM),
      .WriteDataM(WriteDataM),
      .WmaskRawM (WmaskRawM),
      .ReadMemM  (ReadMemM),
      .ReadDataM (ReadDataM),
      .halt      (halt),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .bus_error (bus_error)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One pipeline step: drive the M-stage request, act as the memory with the
   // given wait counts (>= TMO means never ready), and compare with the model.
   task automatic runStep(input logic ld, input logic [3:0] wm, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc,
                          input int dDly, input int fDly,
                          input logic [31:0] dRd, input logic [31:0] fRd);
      logic [31:0] eAddr [2];
      logic [3:0]  eStrb [2];
      logic [31:0] eData [2];
      int          eDly  [2];
      logic [31:0] eRd   [2];
      int          nExp, nSeen, idx, waitCnt, cycles, expCycles;
      logic        hasData, dTo, fTo, prevValid, prevReady, done;

      ReadMemM   = ld;
      WmaskRawM  = wm;
      AluResultM = alu;
      WriteDataM = wd;
      PCF        = pc;

      hasData = ld || (wm != 4'b0000);
      nExp = 0;
      if (hasData) begin
         eAddr[0] = alu & 32'hFFFF_FFFC;
         eStrb[0] = wm;
         eData[0] = wd;
         eDly[0]  = dDly;
         eRd[0]   = dRd;
         nExp = 1;
      end
      eAddr[nExp] = pc & 32'hFFFF_FFFC;
      eStrb[nExp] = 4'b0000;
      eData[nExp] = '0;
      eDly[nExp]  = fDly;
      eRd[nExp]   = fRd;
      nExp++;

      dTo = hasData && (dDly >= TMO);
      fTo = (fDly >= TMO);
      expCycles = (fTo ? TMO - 1 : fDly) + (hasData ? 5 + (dTo ? TMO - 1 : dDly) : 4);
      if (ld) expRd = dTo ? 32'h0 : dRd;
      expInstr = fTo ? NOP : fRd;
      expErr   = expErr | dTo | fTo;

      nSeen = 0; waitCnt = 0; cycles = 0;
      prevValid = 1'b0; prevReady = 1'b0; done = 1'b0;
      while (!done && cycles < 64) begin
         @(negedge clk);
         cycles++;
         if (mem_valid) begin
            if (!prevValid || prevReady) begin
               nSeen++;
               waitCnt = 0;
            end
            idx = (nSeen > 2) ? 1 : nSeen - 1;
            check32("txn_addr", mem_addr, eAddr[idx]);
            check32("txn_wstrb", {28'h0, mem_wstrb}, {28'h0, eStrb[idx]});
            if (eStrb[idx] != 4'b0000) check32("txn_wdata", mem_wdata, eData[idx]);
            mem_ready = (nSeen <= nExp) && (waitCnt == eDly[idx]);
            mem_rdata = mem_ready ? eRd[idx] : $urandom;
            waitCnt++;
         end else begin
            mem_ready = (idleMode == 1) ? 1'b1 : (idleMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
         end
         prevValid = mem_valid;
         prevReady = mem_ready;
         if (!halt) done = 1'b1;
      end
      mem_ready = 1'b0;

      checkInt("step_completed", int'(done), 1);
      checkInt("step_cycles", cycles, expCycles);
      checkInt("txn_count", nSeen, nExp);
      check32("instr", Instr, expInstr);
      check32("read_data", ReadDataM, expRd);
      check32("bus_error", {31'h0, bus_error}, {31'h0, expErr});
   endtask

   initial begin
      int          kind, dd, fd;
      logic [3:0]  wm;
      logic        ld;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check32("rst_halt", {31'h0, halt}, 32'h1);
      check32("rst_valid", {31'h0, mem_valid}, 32'h0);
      check32("rst_addr", mem_addr, 32'h0);
      check32("rst_wdata", mem_wdata, 32'h0);
      check32("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
      check32("rst_instr", Instr, NOP);
      check32("rst_rdata", ReadDataM, 32'h0);
      check32("rst_bus_error", {31'h0, bus_error}, 32'h0);
      #1 reset = 1'b0;

      // Idle steps with ready held high whenever the bus is idle
      idleMode = 1;
      repeat (3) runStep(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0010_0093);
      idleMode = 0;

      // Store, partial lanes; ReadDataM untouched
      runStep(1'b0, 4'b1100, 32'h0000_1006, 32'hABCD_0000, 32'h0000_0004, 0, 0, 32'h0, 32'h0020_0113);
      // Load with 3 wait states (ready coincides with the last allowed wait)
      runStep(1'b1, 4'b0000, 32'h0000_0200, 32'h0, 32'h0000_0008, 3, 0, 32'hDEAD_BEEF, 32'h0030_0193);
      // Fetch whose ready lands on the 4th valid cycle
      runStep(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0000_000C, 0, 3, 32'h0, 32'h0040_0213);
      // Fetch never answered: aborted, NOP delivered, sticky error
      runStep(1'b0, 4'b0000, 32'h0, 32'h0, 32'h0000_0010, 0, NEVER, 32'h0, 32'h1111_1111);
      runStep(1'b0, 4'b0001, 32'h0000_0301, 32'h0000_0055, 32'h0000_0014, 1, 0, 32'h0, 32'h0050_0293);
      // Load never answered: load data forced to zero
      runStep(1'b1, 4'b0000, 32'h0000_0404, 32'h0, 32'h0000_0018, NEVER, 1, 32'h2222_2222, 32'h0060_0313);

      // Reset while the fetch is outstanding
      ReadMemM = 1'b0; WmaskRawM = 4'b0000; PCF = 32'h0000_0040;
      repeat (3) @(negedge clk);
      check32("fwait_valid", {31'h0, mem_valid}, 32'h1);
      #2 reset = 1'b1;
      #1;
      check32("midrst_valid", {31'h0, mem_valid}, 32'h0);
      check32("midrst_halt", {31'h0, halt}, 32'h1);
      check32("midrst_instr", Instr, NOP);
      check32("midrst_bus_error", {31'h0, bus_error}, 32'h0);
      mem_ready = 1'b1;
      mem_rdata = 32'hBADC_0DE5;
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check32("late_ready_instr", Instr, NOP);
      check32("late_ready_valid", {31'h0, mem_valid}, 32'h1);
      check32("late_ready_addr", mem_addr, 32'h0000_0040);
      mem_ready = 1'b0;
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'h0042_0093;
      @(negedge clk);
      mem_ready = 1'b0;
      check32("post_rst_halt", {31'h0, halt}, 32'h0);
      check32("post_rst_instr", Instr, 32'h0042_0093);
      expInstr = 32'h0042_0093;
      expRd    = '0;
      expErr   = 1'b0;

      // Randomized steps
      idleMode = 2;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 3);
         ld = (kind == 1) || (kind == 3);
         wm = (kind >= 2) ? 4'($urandom_range(1, 15)) : 4'b0000;
         dd = $urandom_range(0, 5);
         fd = $urandom_range(0, 5);
         if (dd == 5) dd = NEVER;
         if (fd == 5) fd = NEVER;
         runStep(ld, wm, $urandom, $urandom, $urandom, dd, fd, $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
